// File: rtl/instr_fetch_mem.sv
// Byte-addressed instruction memory with a one-entry fetch response register; latency 1.
// Backpressure: req_ready is low while a load is active or while a full response is not being taken.
module instr_fetch_mem #(
  parameter int MEM_BYTES   = 1024,
  parameter int FETCH_BYTES = 10,
  parameter int PC_W        = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_en,
  input  logic [PC_W-1:0]          load_addr,
  input  logic [7:0]               load_data,
  output logic                     load_err,
  input  logic                     req_valid,
  input  logic [PC_W-1:0]          req_pc,
  output logic                     req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [8*FETCH_BYTES-1:0] rsp_bytes,
  output logic                     rsp_error,
  output logic [15:0]              err_count
);

  localparam int AW = $clog2(MEM_BYTES);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  logic [7:0]               mem_q [MEM_BYTES];
  state_t                   state_q, state_d;
  logic [8*FETCH_BYTES-1:0] rsp_bytes_q, rsp_bytes_d;
  logic                     rsp_error_q, rsp_error_d;
  logic                     load_err_q, load_err_d;
  logic [15:0]              err_count_q, err_count_d;

  logic                     accept;
  logic                     load_in_range;
  logic                     fetch_in_range;
  logic [PC_W:0]            win_last;
  logic [8*FETCH_BYTES-1:0] win_bytes;

  // The window end is formed one bit wider so a pc near 2^PC_W cannot wrap back into range.
  assign win_last       = {1'b0, req_pc} + (PC_W+1)'(FETCH_BYTES - 1);
  assign fetch_in_range = (win_last <= (PC_W+1)'(MEM_BYTES - 1));
  assign load_in_range  = (load_addr < PC_W'(MEM_BYTES));

  for (genvar i = 0; i < FETCH_BYTES; i++) begin : g_win
    assign win_bytes[8*i +: 8] = mem_q[AW'(req_pc + PC_W'(i))];
  end

  assign req_ready = !load_en && ((state_q == EMPTY) || rsp_ready);
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d     = state_q;
    rsp_bytes_d = rsp_bytes_q;
    rsp_error_d = rsp_error_q;
    err_count_d = err_count_q;
    load_err_d  = load_en && !load_in_range;

    if (accept) begin
      state_d     = FULL;
      rsp_bytes_d = fetch_in_range ? win_bytes : '0;
      rsp_error_d = !fetch_in_range;
      if (!fetch_in_range && (err_count_q != 16'hFFFF)) begin
        err_count_d = err_count_q + 16'd1;
      end
    end else if (rsp_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      rsp_bytes_q <= '0;
      rsp_error_q <= 1'b0;
      load_err_q  <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      rsp_bytes_q <= rsp_bytes_d;
      rsp_error_q <= rsp_error_d;
      load_err_q  <= load_err_d;
      err_count_q <= err_count_d;
    end
  end

  // Memory is deliberately left out of reset so a loaded program survives it.
  always_ff @(posedge clk) begin
    if (!rst && load_en && load_in_range) begin
      mem_q[AW'(load_addr)] <= load_data;
    end
  end

  assign rsp_valid = (state_q == FULL);
  assign rsp_bytes = rsp_bytes_q;
  assign rsp_error = rsp_error_q;
  assign load_err  = load_err_q;
  assign err_count = err_count_q;

endmodule

// File: doc/instr_fetch_mem.md
INSTR_FETCH_MEM -- requirements
Module: instr_fetch_mem

Interface
REQ-001 The module SHALL have parameter MEM_BYTES, default 1024, meaning instruction memory depth in bytes.
REQ-002 The module SHALL have parameter FETCH_BYTES, default 10, meaning bytes returned per fetch (1..16).
REQ-003 The module SHALL have parameter PC_W, default 64, meaning width of every address port.
REQ-004 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 load_en  input  1  byte-write strobe for program loading.
REQ-007 load_addr  input  PC_W  byte address of the load write.
REQ-008 load_data  input  8  byte to write.
REQ-009 load_err  output  1  one-cycle pulse: the load address was out of range.
REQ-010 req_valid  input  1  a fetch request is present.
REQ-011 req_pc  input  PC_W  fetch start address.
REQ-012 req_ready  output  1  the request is accepted this cycle.
REQ-013 rsp_valid  output  1  the response register holds a response.
REQ-014 rsp_ready  input  1  the consumer takes the response this cycle.
REQ-015 rsp_bytes  output  8*FETCH_BYTES  fetched bytes; byte i (mem[pc+i]) at bits [8i+7:8i].
REQ-016 rsp_error  output  1  the response is an imem error.
REQ-017 err_count  output  16  number of error responses issued since reset.

Function
REQ-018 The response path SHALL be a one-entry register with two states: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-019 req_ready SHALL be (load_en==0) AND (state EMPTY OR rsp_ready==1), computed combinationally.
REQ-020 A fetch SHALL be accepted when req_valid AND req_ready, and its response SHALL appear with rsp_valid=1 on the next cycle (latency 1).
REQ-021 EMPTY->FULL on accept; FULL->EMPTY on rsp_ready with no accept; FULL->FULL with new data on rsp_ready plus accept; otherwise state holds.
REQ-022 While FULL and rsp_ready=0, rsp_bytes and rsp_error SHALL stay stable.
REQ-023 A fetch SHALL be in range only if req_pc+FETCH_BYTES-1 <= MEM_BYTES-1, evaluated without overflow at PC_W+1 bits.
REQ-024 An in-range fetch SHALL return rsp_error=0 and bytes mem[req_pc]..mem[req_pc+FETCH_BYTES-1].
REQ-025 An out-of-range fetch (including a window that straddles the top of memory, and req_pc wrap at 2^PC_W) SHALL return rsp_error=1 with rsp_bytes all zero; memory SHALL NOT wrap.
REQ-026 err_count SHALL increment by 1 per accepted out-of-range fetch and saturate at 16'hFFFF.
REQ-027 A load with load_addr <= MEM_BYTES-1 SHALL write load_data into mem[load_addr] at the clock edge.
REQ-028 A load with load_addr >= MEM_BYTES SHALL NOT write memory and SHALL set load_err=1 for the next cycle only.
REQ-029 Load has priority: while load_en=1 no fetch SHALL be accepted (req_ready=0), and an already FULL response SHALL still drain on rsp_ready.
REQ-030 A fetch accepted in the cycle immediately after a load to an address in its window SHALL return the newly written byte.

Reset
REQ-031 On rst=1 at a clock edge the state SHALL become EMPTY: rsp_valid=0, rsp_error=0, rsp_bytes=0, load_err=0, err_count=0.
REQ-032 Reset SHALL discard any pending response; no response for a request accepted before reset SHALL appear afterwards.
REQ-033 Memory contents SHALL NOT be cleared by reset.
REQ-034 rst SHALL take priority over load_en and req_valid in the same cycle; no write or accept SHALL occur.

Verification
REQ-035 Load bytes 0x30,0xF2,0x0A,0,0,0,0,0,0,0 to addresses 0..9; fetch pc=0 -> next cycle rsp_valid=1, rsp_error=0, rsp_bytes[7:0]=0x30, [15:8]=0xF2, [23:16]=0x0A.
REQ-036 Fetch pc=1014 -> rsp_error=0; fetch pc=1015 -> rsp_error=1, rsp_bytes=0, err_count=1; fetch pc=2^64-1 -> rsp_error=1, err_count=2.
REQ-037 Hold rsp_ready=0 for 3 cycles with req_valid=1 -> req_ready=0 and rsp_bytes stable; then rsp_ready=1 with req_valid=1 each cycle -> one response per cycle, no bubbles.
REQ-038 load_en=1 with load_addr=1024 -> no write, load_err=1 for exactly one cycle, req_ready=0 during the load cycle.
REQ-039 Assert rst while FULL -> next cycle rsp_valid=0, err_count=0; then refetch pc=0 -> previously loaded bytes intact.
REQ-040 Write 0xAB to address 5, fetch pc=0 the next cycle -> rsp_bytes[47:40]=0xAB.
